// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with arbitrary depth, occupancy count, threshold flags,
// overflow/underflow pulses and selectable first-word-fall-through read.
module sync_fifo_flags #(
    parameter int D_WIDTH  = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0,
    localparam int A_W     = $clog2(DEPTH),
    localparam int C_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [D_WIDTH-1:0] data_in,
    input  logic               rd_en,
    output logic [D_WIDTH-1:0] data_out,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [C_W-1:0]     count,
    output logic               overflow,
    output logic               underflow
);
    localparam logic [A_W-1:0] LAST   = A_W'(DEPTH - 1);
    localparam logic [C_W-1:0] FULL_C = C_W'(DEPTH);
    localparam logic [C_W-1:0] AF_C   = C_W'(AF_LEVEL);
    localparam logic [C_W-1:0] AE_C   = C_W'(AE_LEVEL);
    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_W-1:0]     wr_ptr, rd_ptr;
    logic               wr_acc, rd_acc;
    // Status is decoded from the registered count only, so no input reaches a flag combinationally.
    assign fifo_full    = count == FULL_C;
    assign fifo_empty   = count == '0;
    assign almost_full  = count >= AF_C;
    assign almost_empty = count <= AE_C;
    assign wr_acc       = wr_en & ~fifo_full;
    assign rd_acc       = rd_en & ~fifo_empty;
    always_ff @(posedge clk)
        if (wr_acc & ~rst) mem[wr_ptr] <= data_in;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + A_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + A_W'(1);
            if (wr_acc != rd_acc) count <= wr_acc ? count + C_W'(1) : count - C_W'(1);
            overflow  <= wr_en & fifo_full;
            underflow <= rd_en & fifo_empty;
        end
    end
    if (FWFT != 0) begin : g_fwft
        assign data_out = mem[rd_ptr];
    end else begin : g_std
        always_ff @(posedge clk)
            if (rst) data_out <= '0;
            else if (rd_acc) data_out <= mem[rd_ptr];
    end
endmodule
